// File: rtl/key_debounce.sv
// Push-button front end: synchronizes an active-low bouncing key and produces a
// debounced level plus single-cycle press, release and long-press pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 240000,
    parameter int LONG_CYC     = 12000000,
    parameter int CNT_W        = 24
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             p;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic             long_done;

    // Sync flops idle at 1 so a reset never looks like a press.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    assign p = ~s2;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            dcnt          <= '0;
            hcnt          <= '0;
            long_done     <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state <= IDLE;
                    end else if (dcnt == DEB_LAST) begin
                        state       <= PRESSED;
                        key_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        hcnt        <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end else if (!long_done && hcnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end else if (!long_done) begin
                        hcnt <= hcnt + CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // A return to pressed is bounce: hold progress is kept.
                    if (p) begin
                        state <= PRESSED;
                    end else if (dcnt == DEB_LAST) begin
                        state         <= IDLE;
                        key_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
